// File: rtl/nor8_pkg.sv
// nor8_pkg: shared width constant and registered result record for the NOR lane
package nor8_pkg;
  localparam int NOR8_WIDTH = 8;
  typedef struct packed {
    logic [NOR8_WIDTH-1:0] z;
    logic                  zero;
    logic                  ones;
    logic                  par;
  } nor8_res_t;
endpackage

// File: rtl/nor8_lane_if.sv
// nor8_lane_if: operand/result valid-ready bundle of the NOR lane
interface nor8_lane_if;
  import nor8_pkg::*;
  logic [NOR8_WIDTH-1:0] a;
  logic [NOR8_WIDTH-1:0] b;
  logic [NOR8_WIDTH-1:0] z;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic flag_zero;
  logic flag_ones;
  logic flag_par;
  modport master(output a, b, in_valid, out_ready, input in_ready, z, out_valid, flag_zero, flag_ones, flag_par);
  modport slave(input a, b, in_valid, out_ready, output in_ready, z, out_valid, flag_zero, flag_ones, flag_par);
endinterface

// File: rtl/nor8_skid_buf.sv
// nor8_skid_buf: 1-entry pipeline register or 2-entry skid buffer (registered in_ready) of nor8_res_t
module nor8_skid_buf
  import nor8_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  output logic      in_ready,
  input  nor8_res_t din,
  output logic      out_valid,
  input  logic      out_ready,
  output nor8_res_t dout
);
  logic push;
  assign push = in_valid && in_ready;
  if (DEPTH == 2) begin : g_skid
    nor8_res_t skid_d;
    logic skid_v, full_q, head_ld, ov_n, sv_n;
    // full_q is the only source of in_ready, so out_ready never reaches it combinationally
    assign in_ready = !rst && !full_q;
    always_comb begin
      head_ld = !out_valid || out_ready;
      ov_n = head_ld ? (skid_v || push) : out_valid;
      sv_n = head_ld ? (skid_v && push) : (skid_v || push);
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid <= 1'b0;
        skid_v <= 1'b0;
        full_q <= 1'b0;
        dout <= '0;
        skid_d <= '0;
      end else begin
        out_valid <= ov_n;
        skid_v <= sv_n;
        full_q <= ov_n && sv_n;
        if (head_ld && (skid_v || push)) dout <= skid_v ? skid_d : din;
        if (push && (skid_v || !head_ld)) skid_d <= din;
      end
    end
  end else begin : g_reg
    assign in_ready = !rst && (!out_valid || out_ready);
    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid <= 1'b0;
        dout <= '0;
      end else begin
        out_valid <= push || (out_valid && !out_ready);
        if (push) dout <= din;
      end
    end
  end
endmodule

// File: rtl/nor8_lane.sv
// nor8_lane: bitwise NOR lane with zero/ones/parity flags; define NOR8_SKID_EN for the 2-entry skid output
module nor8_lane
  import nor8_pkg::*;
(
  input logic         clk,
  input logic         rst,
  nor8_lane_if.slave  bus
);
`ifdef NOR8_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  logic [NOR8_WIDTH-1:0] z_n;
  nor8_res_t res_in, res_out;
  assign z_n = ~(bus.a | bus.b);
  assign res_in = '{z: z_n, zero: ~|z_n, ones: &z_n, par: ^z_n};
  nor8_skid_buf #(.DEPTH(DEPTH)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .din      (res_in),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .dout     (res_out)
  );
  assign bus.z = res_out.z;
  assign bus.flag_zero = res_out.zero;
  assign bus.flag_ones = res_out.ones;
  assign bus.flag_par = res_out.par;
endmodule

// File: tb/tb_nor8_lane.sv
// tb_nor8_lane: directed vector table, backpressure/reset sequences and random streaming against an in-order scoreboard
module tb_nor8_lane;
`ifdef NOR8_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] z;
    logic [2:0] f;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [10:0] q[$];
  vec_t vecs[10];
  nor8_lane_if bus();
  nor8_lane dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] z;
    z = ~(a | b);
    return {z, z == 8'h00, z == 8'hff, ^z};
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // inputs change 1 time unit after posedge, so negedge sees them stable until the next edge
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("sb_unexpected", 32'(bus.out_valid), 32'(0));
        else chk("sb", 32'({bus.z, bus.flag_zero, bus.flag_ones, bus.flag_par}), 32'(q.pop_front()));
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [10:0] snap;
    logic [7:0] ra, rb;
    int acc;
    vecs[0] = '{8'h12, 8'h45, 8'ha8, 3'b001};
    vecs[1] = '{8'h92, 8'h47, 8'h28, 3'b000};
    vecs[2] = '{8'h1a, 8'h05, 8'he0, 3'b001};
    vecs[3] = '{8'h32, 8'hc5, 8'h08, 3'b001};
    vecs[4] = '{8'hff, 8'h00, 8'h00, 3'b100};
    vecs[5] = '{8'h00, 8'h00, 8'hff, 3'b010};
    vecs[6] = '{8'h0f, 8'hf0, 8'h00, 3'b100};
    vecs[7] = '{8'h55, 8'h00, 8'haa, 3'b000};
    vecs[8] = '{8'h3c, 8'hc3, 8'h00, 3'b100};
    vecs[9] = '{8'h80, 8'h00, 8'h7f, 3'b001};
    bus.a = 8'h12;
    bus.b = 8'h45;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) cyc();
    chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_z_flags", 32'({bus.z, bus.flag_zero, bus.flag_ones, bus.flag_par}), 32'(0));
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
    cyc();
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'(0));
    for (int i = 0; i < 10; i++) begin
      bus.a = vecs[i].a;
      bus.b = vecs[i].b;
      bus.in_valid = 1'b1;
      cyc();
      chk("vec_valid", 32'(bus.out_valid), 32'(1));
      chk("vec_z", 32'(bus.z), 32'(vecs[i].z));
      chk("vec_flags", 32'({bus.flag_zero, bus.flag_ones, bus.flag_par}), 32'(vecs[i].f));
    end
    bus.in_valid = 1'b0;
    cyc();
    chk("idle_valid", 32'(bus.out_valid), 32'(0));
    chk("idle_hold", 32'({bus.z, bus.flag_zero, bus.flag_ones, bus.flag_par}), 32'({8'h7f, 3'b001}));
    // backpressure: 5 stalled cycles, a new operand offered after each acceptance
    acc = 0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.a = vecs[acc].a;
      bus.b = vecs[acc].b;
      #1;
      if (bus.in_ready) acc++;
      cyc();
      if (k == 0) snap = {bus.z, bus.flag_zero, bus.flag_ones, bus.flag_par};
      chk("bp_valid", 32'(bus.out_valid), 32'(1));
      chk("bp_stable", 32'({bus.z, bus.flag_zero, bus.flag_ones, bus.flag_par}), 32'(snap));
    end
    chk("bp_first", 32'(snap), 32'({8'ha8, 3'b001}));
    chk("bp_depth", 32'(acc), 32'(DEPTH));
    chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 10 && q.size() != 0; n++) cyc();
    chk("bp_drained", 32'(q.size()), 32'(0));
    cyc();
    chk("bp_idle", 32'(bus.out_valid), 32'(0));
    // reset with results pending and an operand offered during rst
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 8'h0f;
    bus.b = 8'h00;
    repeat (2) cyc();
    chk("rst2_pending", 32'(bus.out_valid), 32'(1));
    rst = 1'b1;
    bus.a = 8'h01;
    bus.b = 8'h02;
    cyc();
    chk("rst2_valid", 32'(bus.out_valid), 32'(0));
    chk("rst2_z_flags", 32'({bus.z, bus.flag_zero, bus.flag_ones, bus.flag_par}), 32'(0));
    chk("rst2_in_ready", 32'(bus.in_ready), 32'(0));
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cyc();
      chk("rst2_no_output", 32'(bus.out_valid), 32'(0));
    end
    // random streaming with 50% out_ready
    acc = 0;
    ra = 8'($urandom);
    rb = 8'($urandom);
    for (int n = 0; n < 2000 && acc < 256; n++) begin
      bus.a = ra;
      bus.b = rb;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'($urandom);
      #1;
      if (bus.in_ready) begin
        acc++;
        ra = 8'($urandom);
        rb = 8'($urandom);
      end
      cyc();
    end
    chk("stream_count", 32'(acc), 32'(256));
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 10 && q.size() != 0; n++) cyc();
    chk("stream_drained", 32'(q.size()), 32'(0));
    cyc();
    // full throughput with out_ready held high
    for (int n = 0; n < 20; n++) begin
      bus.a = 8'(n * 13);
      bus.b = 8'(n * 7);
      bus.in_valid = 1'b1;
      #1;
      chk("tp_in_ready", 32'(bus.in_ready), 32'(1));
      cyc();
      chk("tp_out_valid", 32'(bus.out_valid), 32'(1));
    end
    bus.in_valid = 1'b0;
    for (int n = 0; n < 10 && q.size() != 0; n++) cyc();
    chk("tp_drained", 32'(q.size()), 32'(0));
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
